// File: rtl/conn_ctrl_sequencer.sv
// Bind/unbind control sequencer: queues host requests, issues them one at a time with timeout.
// Optional re-issue on timeout is enabled by defining CONN_CTRL_RETRY_EN.
module conn_ctrl_sequencer #(
    parameter int CONN_ID_WIDTH  = 18,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RETRY_MAX      = 3
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_areset,
    input  logic                     s00_axis_req_valid,
    output logic                     s00_axis_req_ready,
    input  logic [31:0]              s00_axis_req_ipAddr,
    input  logic [15:0]              s00_axis_req_udpPort,
    input  logic                     s00_axis_req_bind,
    input  logic [7:0]               s00_axis_req_tag,
    output logic                     m02_axis_tvalid,
    input  logic                     m02_axis_tready,
    output logic [127:0]             m02_axis_tdata,
    output logic                     m02_axis_tlast,
    output logic [6:0]               m02_axis_tstrb,
    input  logic                     s02_axis_tvalid,
    output logic                     s02_axis_tready,
    input  logic [31:0]              s02_axis_tdata,
    output logic                     m00_axis_cpl_valid,
    input  logic                     m00_axis_cpl_ready,
    output logic [7:0]               m00_axis_cpl_tag,
    output logic [1:0]               m00_axis_cpl_status,
    output logic [CONN_ID_WIDTH-1:0] m00_axis_cpl_connectionId,
    output logic                     busy,
    output logic [15:0]              stat_ok,
    output logic [15:0]              stat_fail,
    output logic [15:0]              stat_stray
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] ST_OK = 2'd0, ST_NACK = 2'd1, ST_FULL = 2'd2, ST_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state, state_next;
    logic [56:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_next;
    logic [56:0]    head;
    logic [7:0]     hold_tag;
    logic [TW-1:0]  timer;
    logic           push, pop, rsp_fire, rsp_take, expire, retry, stray, can_retry, cpl_hs;
    logic           rsp_ack, rsp_full;
    logic           unused_rsp_bits;

    assign s00_axis_req_ready = (count != CW'(FIFO_DEPTH));
    assign push               = s00_axis_req_valid & s00_axis_req_ready;
    assign head               = fifo_mem[rd_ptr];
    assign s02_axis_tready    = !s00_axis_areset && (state != CPL);
    assign rsp_fire           = s02_axis_tvalid & s02_axis_tready;
    assign rsp_ack            = s02_axis_tdata[CONN_ID_WIDTH];
    assign rsp_full           = s02_axis_tdata[CONN_ID_WIDTH+1];
    assign cpl_hs             = m00_axis_cpl_valid & m00_axis_cpl_ready;
    assign m02_axis_tlast     = 1'b1;
    assign m02_axis_tstrb     = 7'h7F;
    assign unused_rsp_bits    = ^s02_axis_tdata[31:CONN_ID_WIDTH+2];

`ifdef CONN_CTRL_RETRY_EN
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    logic [RW-1:0] retry_cnt;

    assign can_retry = (retry_cnt < RW'(RETRY_MAX));

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            retry_cnt <= '0;
        end else if (pop) begin
            retry_cnt <= '0;
        end else if (retry) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) state <= IDLE;
        else                 state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rsp_take   = 1'b0;
        expire     = 1'b0;
        retry      = 1'b0;
        stray      = 1'b0;
        case (state)
            IDLE: begin
                stray = rsp_fire;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                stray = rsp_fire;
                if (m02_axis_tvalid && m02_axis_tready) state_next = WAIT;
            end
            WAIT: begin
                // A response on the expiry cycle takes precedence over the timeout.
                if (rsp_fire) begin
                    rsp_take   = 1'b1;
                    state_next = CPL;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (can_retry) begin
                        retry      = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        expire     = 1'b1;
                        state_next = CPL;
                    end
                end
            end
            CPL: begin
                if (cpl_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (push) fifo_mem[wr_ptr] <= {s00_axis_req_tag, s00_axis_req_bind,
                                       s00_axis_req_udpPort, s00_axis_req_ipAddr};
        if (pop) hold_tag <= head[56:49];
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            count                     <= '0;
            timer                     <= '0;
            busy                      <= 1'b0;
            m02_axis_tvalid           <= 1'b0;
            m02_axis_tdata            <= '0;
            m00_axis_cpl_valid        <= 1'b0;
            m00_axis_cpl_tag          <= '0;
            m00_axis_cpl_status       <= '0;
            m00_axis_cpl_connectionId <= '0;
            stat_ok                   <= '0;
            stat_fail                 <= '0;
            stat_stray                <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            busy  <= (state_next != IDLE) || (count_next != '0);

            if (pop) begin
                m02_axis_tdata  <= {79'd0, head[48:0]};
                m02_axis_tvalid <= 1'b1;
            end else if (retry) begin
                m02_axis_tvalid <= 1'b1;
            end else if (state == ISSUE && state_next == WAIT) begin
                m02_axis_tvalid <= 1'b0;
            end

            if (state == ISSUE) timer <= '0;
            else if (state == WAIT) timer <= timer + TW'(1);

            if (rsp_take) begin
                m00_axis_cpl_valid        <= 1'b1;
                m00_axis_cpl_tag          <= hold_tag;
                m00_axis_cpl_status       <= rsp_full ? ST_FULL : (rsp_ack ? ST_OK : ST_NACK);
                m00_axis_cpl_connectionId <= (!rsp_full && rsp_ack) ?
                                             s02_axis_tdata[CONN_ID_WIDTH-1:0] : '0;
            end else if (expire) begin
                m00_axis_cpl_valid        <= 1'b1;
                m00_axis_cpl_tag          <= hold_tag;
                m00_axis_cpl_status       <= ST_TIMEOUT;
                m00_axis_cpl_connectionId <= '0;
            end else if (cpl_hs) begin
                m00_axis_cpl_valid <= 1'b0;
            end

            if (cpl_hs) begin
                if (m00_axis_cpl_status == ST_OK) stat_ok   <= sat_inc(stat_ok);
                else                              stat_fail <= sat_inc(stat_fail);
            end
            if (stray) stat_stray <= sat_inc(stat_stray);
        end
    end
endmodule

// File: tb/tb_conn_ctrl_sequencer.sv
// Directed bench for conn_ctrl_sequencer (TIMEOUT_CYCLES = 16, RETRY_MAX = 3, FIFO_DEPTH = 8).
module tb_conn_ctrl_sequencer;
    localparam int CIDW = 18;
`ifdef CONN_CTRL_RETRY_EN
    localparam int EXP_ISSUES = 4;
`else
    localparam int EXP_ISSUES = 1;
`endif

    logic            clk = 1'b0;
    logic            areset;
    logic            req_valid, req_ready, req_bind;
    logic [31:0]     req_ip;
    logic [15:0]     req_port;
    logic [7:0]      req_tag;
    logic            m02_tvalid, m02_tready, m02_tlast;
    logic [127:0]    m02_tdata;
    logic [6:0]      m02_tstrb;
    logic            s02_tvalid, s02_tready;
    logic [31:0]     s02_tdata;
    logic            cpl_valid, cpl_ready;
    logic [7:0]      cpl_tag;
    logic [1:0]      cpl_status;
    logic [CIDW-1:0] cpl_cid;
    logic            busy;
    logic [15:0]     stat_ok, stat_fail, stat_stray;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int issue_q[$];

    always #5 clk = ~clk;

    conn_ctrl_sequencer #(
        .CONN_ID_WIDTH(CIDW), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16), .RETRY_MAX(3)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_areset(areset),
        .s00_axis_req_valid(req_valid), .s00_axis_req_ready(req_ready),
        .s00_axis_req_ipAddr(req_ip), .s00_axis_req_udpPort(req_port),
        .s00_axis_req_bind(req_bind), .s00_axis_req_tag(req_tag),
        .m02_axis_tvalid(m02_tvalid), .m02_axis_tready(m02_tready),
        .m02_axis_tdata(m02_tdata), .m02_axis_tlast(m02_tlast), .m02_axis_tstrb(m02_tstrb),
        .s02_axis_tvalid(s02_tvalid), .s02_axis_tready(s02_tready), .s02_axis_tdata(s02_tdata),
        .m00_axis_cpl_valid(cpl_valid), .m00_axis_cpl_ready(cpl_ready),
        .m00_axis_cpl_tag(cpl_tag), .m00_axis_cpl_status(cpl_status),
        .m00_axis_cpl_connectionId(cpl_cid), .busy(busy),
        .stat_ok(stat_ok), .stat_fail(stat_fail), .stat_stray(stat_stray)
    );

    always @(posedge clk) begin
        if (m02_tvalid && m02_tready) issue_q.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] ip, input logic [15:0] port, input logic b,
                        input logic [7:0] tag);
        int n = 0;
        req_ip = ip; req_port = port; req_bind = b; req_tag = tag; req_valid = 1'b1;
        while (!req_ready && n < 100) begin tick(); n++; end
        chk("push_wait", 128'(n < 100), 128'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!m02_tvalid && n < 100) begin tick(); n++; end
        chk("issue_wait", 128'(n < 100), 128'd1);
    endtask

    task automatic respond(input logic [CIDW-1:0] cid, input logic ack, input logic full);
        s02_tvalid = 1'b1;
        s02_tdata  = {12'd0, full, ack, cid};
        tick();
        s02_tvalid = 1'b0;
    endtask

    task automatic serve(input logic [CIDW-1:0] cid, input logic ack, input logic full,
                         input logic [7:0] etag, input logic [1:0] est, input logic [CIDW-1:0] ecid);
        wait_issue();
        tick();
        respond(cid, ack, full);
        chk("cpl_valid", 128'(cpl_valid), 128'd1);
        chk("cpl_tag", 128'(cpl_tag), 128'(etag));
        chk("cpl_status", 128'(cpl_status), 128'(est));
        chk("cpl_cid", 128'(cpl_cid), 128'(ecid));
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("cpl_drop", 128'(cpl_valid), 128'd0);
    endtask

    initial begin
        int q0;
        int n;
        areset = 1'b1; req_valid = 1'b0; req_ip = '0; req_port = '0; req_bind = 1'b0;
        req_tag = '0; m02_tready = 1'b1; s02_tvalid = 1'b0; s02_tdata = '0; cpl_ready = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 128'(req_ready), 128'd1);
        chk("rst_m02_tvalid", 128'(m02_tvalid), 128'd0);
        chk("rst_m02_tdata", m02_tdata, 128'd0);
        chk("rst_s02_tready", 128'(s02_tready), 128'd0);
        chk("rst_cpl_valid", 128'(cpl_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_stats", {80'd0, stat_ok, stat_fail, stat_stray}, 128'd0);
        chk("tlast_tstrb", 128'({m02_tlast, m02_tstrb}), 128'h FF);
        areset = 1'b0;
        tick();

        // Basic bind: 10.0.0.5:4791 tag 0x11, ack with connId 0x00ABC
        push(32'h0A00_0005, 16'd4791, 1'b1, 8'h11);
        chk("lat_tvalid_n1", 128'(m02_tvalid), 128'd0);
        chk("busy_after_push", 128'(busy), 128'd1);
        tick();
        chk("lat_tvalid_n2", 128'(m02_tvalid), 128'd1);
        chk("bind_tdata", m02_tdata, {79'd0, 1'b1, 16'h12B7, 32'h0A00_0005});
        tick();
        chk("tvalid_after_hs", 128'(m02_tvalid), 128'd0);
        respond(18'h00ABC, 1'b1, 1'b0);
        chk("basic_cpl_valid", 128'(cpl_valid), 128'd1);
        chk("basic_cpl_tag", 128'(cpl_tag), 128'h11);
        chk("basic_cpl_status", 128'(cpl_status), 128'd0);
        chk("basic_cpl_cid", 128'(cpl_cid), 128'h00ABC);
        chk("cpl_s02_tready", 128'(s02_tready), 128'd0);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("basic_cpl_drop", 128'(cpl_valid), 128'd0);
        chk("basic_stat_ok", 128'(stat_ok), 128'd1);
        chk("basic_busy_clear", 128'(busy), 128'd0);

        // Backpressure: one request parks in the holding register, eight fill the FIFO
        m02_tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push(32'hC0A8_0000 + 32'(i), 16'd1000 + 16'(i), i[0], 8'h20 + 8'(i));
            if (i == 7) chk("ready_after_8", 128'(req_ready), 128'd1);
        end
        chk("ready_after_9", 128'(req_ready), 128'd0);
        chk("stall_tdata_ip", 128'(m02_tdata[31:0]), 128'hC0A8_0000);
        req_tag = 8'h29; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_held", 128'({req_ready, m02_tvalid}), 128'b01);
        end
        req_valid = 1'b0;
        m02_tready = 1'b1;
        for (int i = 0; i < 9; i++)
            serve(18'(i + 1), 1'b1, 1'b0, 8'h20 + 8'(i), 2'd0, 18'(i + 1));
        chk("fifo_stat_ok", 128'(stat_ok), 128'd10);

        // No response: timeout with bounded retry
        q0 = issue_q.size();
        push(32'h0A00_0009, 16'd7, 1'b0, 8'h30);
        n = 0;
        while (!cpl_valid && n < 400) begin tick(); n++; end
        chk("to_cpl_seen", 128'(n < 400), 128'd1);
        chk("to_issues", 128'(issue_q.size() - q0), 128'(EXP_ISSUES));
        for (int i = q0 + 1; i < issue_q.size(); i++)
            chk("to_gap_ge16", 128'(issue_q[i] - issue_q[i-1] >= 16), 128'd1);
        chk("to_status", 128'(cpl_status), 128'd3);
        chk("to_tag", 128'(cpl_tag), 128'h30);
        chk("to_cid", 128'(cpl_cid), 128'd0);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("to_stat_fail", 128'(stat_fail), 128'd1);

        // FULL beats ack; completion held while cpl_ready is low
        push(32'h0A00_000A, 16'd8, 1'b1, 8'h40);
        wait_issue();
        tick();
        respond(18'h00155, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("full_hold", 128'({cpl_valid, s02_tready, cpl_status, cpl_tag, cpl_cid}),
                {94'd0, 1'b1, 1'b0, 2'd2, 8'h40, 18'd0});
            tick();
        end
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("full_stat_fail", 128'(stat_fail), 128'd2);

        // Stray response while idle
        respond(18'h00077, 1'b1, 1'b0);
        chk("stray_count", 128'(stat_stray), 128'd1);
        chk("stray_no_cpl", 128'({cpl_valid, busy}), 128'd0);

        // Response on the exact expiry cycle (timer = 15) wins, no re-issue
        q0 = issue_q.size();
        push(32'h0A00_000B, 16'd9, 1'b0, 8'h50);
        wait_issue();
        tick();
        repeat (15) tick();
        respond(18'h00123, 1'b0, 1'b0);
        chk("edge_cpl_valid", 128'(cpl_valid), 128'd1);
        chk("edge_status", 128'(cpl_status), 128'd1);
        chk("edge_tag", 128'(cpl_tag), 128'h50);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        repeat (3) tick();
        chk("edge_issues", 128'(issue_q.size() - q0), 128'd1);
        chk("edge_stat_fail", 128'(stat_fail), 128'd3);

        // Reset while waiting for a response
        push(32'h0A00_000C, 16'd10, 1'b1, 8'h60);
        wait_issue();
        repeat (3) tick();
        areset = 1'b1;
        tick();
        chk("wrst_outputs", 128'({req_ready, m02_tvalid, s02_tready, cpl_valid, busy}),
            128'b10000);
        chk("wrst_tdata", m02_tdata, 128'd0);
        chk("wrst_cpl", 128'({cpl_tag, cpl_status, cpl_cid}), 128'd0);
        chk("wrst_stats", {80'd0, stat_ok, stat_fail, stat_stray}, 128'd0);
        areset = 1'b0;
        respond(18'h00099, 1'b1, 1'b0);
        chk("late_stray", 128'(stat_stray), 128'd1);
        push(32'h0A00_000D, 16'd11, 1'b1, 8'h61);
        serve(18'h0002A, 1'b1, 1'b0, 8'h61, 2'd0, 18'h0002A);
        chk("post_rst_ok", 128'(stat_ok), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
